// File: rtl/conv_mul_array.sv
// Lane-parallel signed 16x16 multiplier array with per-lane valid pipeline,
// global clock enable and a saturating activity counter.
module conv_mul_array #(
  parameter int ATOMIC_K    = 8,
  parameter int ATOMIC_C    = 4,
  parameter int MUL_LATENCY = 2,
  parameter int SIM_DELAY   = 1
) (
  input  logic                            mac_array_aclk,
  input  logic                            mac_array_aresetn,
  input  logic                            mac_array_aclken,
  input  logic [ATOMIC_K*ATOMIC_C*16-1:0] mul_op_a,
  input  logic [ATOMIC_K*ATOMIC_C*16-1:0] mul_op_b,
  input  logic [ATOMIC_K-1:0]             mul_ce,
  output logic [ATOMIC_K*ATOMIC_C*32-1:0] mul_res,
  output logic [ATOMIC_K-1:0]             mul_res_vld,
  input  logic                            clr_stat,
  output logic [31:0]                     mul_act_cnt
);

  localparam int LaneIn  = ATOMIC_C * 16;
  localparam int LaneOut = ATOMIC_C * 32;

  // Register updates are zero-delay in RTL; the parameter is kept for interface compatibility.
  if (SIM_DELAY < 0) begin : g_sim_delay_unused
  end

  function automatic logic [31:0] f_mul(input logic [15:0] a, input logic [15:0] b);
    f_mul = 32'($signed(a)) * 32'($signed(b));
  endfunction

  logic [31:0] r_act_cnt;

  always_ff @(posedge mac_array_aclk or negedge mac_array_aresetn) begin
    if (!mac_array_aresetn) begin
      r_act_cnt <= '0;
    end else if (mac_array_aclken) begin
      if (clr_stat) begin
        r_act_cnt <= '0;
      end else if ((|mul_ce) && (r_act_cnt != 32'hFFFF_FFFF)) begin
        r_act_cnt <= r_act_cnt + 32'd1;
      end
    end
  end

  assign mul_act_cnt = r_act_cnt;

  for (genvar k = 0; k < ATOMIC_K; k++) begin : g_lane
    logic [MUL_LATENCY:1] r_vld;
    logic [LaneOut-1:0]   w_prod;
    logic [LaneOut-1:0]   w_res;

    if (MUL_LATENCY == 1) begin : g_lat1
      logic [LaneOut-1:0] r_res;

      for (genvar j = 0; j < ATOMIC_C; j++) begin : g_mul
        assign w_prod[j*32 +: 32] = f_mul(mul_op_a[k*LaneIn + j*16 +: 16],
                                          mul_op_b[k*LaneIn + j*16 +: 16]);
      end

      always_ff @(posedge mac_array_aclk or negedge mac_array_aresetn) begin
        if (!mac_array_aresetn) begin
          r_vld <= '0;
          r_res <= '0;
        end else if (mac_array_aclken) begin
          r_vld <= mul_ce[k];
          if (mul_ce[k]) begin
            r_res <= w_prod;
          end
        end
      end

      assign w_res = r_res;
    end else begin : g_latn
      logic [LaneIn-1:0]  r_a;
      logic [LaneIn-1:0]  r_b;
      logic [LaneOut-1:0] r_stg [2:MUL_LATENCY];

      for (genvar j = 0; j < ATOMIC_C; j++) begin : g_mul
        assign w_prod[j*32 +: 32] = f_mul(r_a[j*16 +: 16], r_b[j*16 +: 16]);
      end

      // Each data stage only moves when the stage behind it holds a valid word,
      // so idle lanes keep presenting their last product.
      always_ff @(posedge mac_array_aclk or negedge mac_array_aresetn) begin
        if (!mac_array_aresetn) begin
          r_vld <= '0;
          r_a   <= '0;
          r_b   <= '0;
          for (int s = 2; s <= MUL_LATENCY; s++) begin
            r_stg[s] <= '0;
          end
        end else if (mac_array_aclken) begin
          r_vld <= {r_vld[MUL_LATENCY-1:1], mul_ce[k]};
          if (mul_ce[k]) begin
            r_a <= mul_op_a[k*LaneIn +: LaneIn];
            r_b <= mul_op_b[k*LaneIn +: LaneIn];
          end
          if (r_vld[1]) begin
            r_stg[2] <= w_prod;
          end
          for (int s = 3; s <= MUL_LATENCY; s++) begin
            if (r_vld[s-1]) begin
              r_stg[s] <= r_stg[s-1];
            end
          end
        end
      end

      assign w_res = r_stg[MUL_LATENCY];
    end

    assign mul_res[k*LaneOut +: LaneOut] = w_res;
    assign mul_res_vld[k]                = r_vld[MUL_LATENCY];
  end

endmodule

// File: tb/tb_conv_mul_array.sv
// Directed bench for conv_mul_array at default parameters (K=8, C=4, latency 2).
module tb_conv_mul_array;

  localparam int K = 8;
  localparam int C = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic              aclken;
  logic [K*C*16-1:0] op_a;
  logic [K*C*16-1:0] op_b;
  logic [K-1:0]      ce;
  logic [K*C*32-1:0] res;
  logic [K-1:0]      vld;
  logic              clr;
  logic [31:0]       cnt;

  int total = 0;
  int bad   = 0;
  int vcnt [K];
  logic [K*C*32-1:0] exp_vec;

  conv_mul_array #(
    .ATOMIC_K   (K),
    .ATOMIC_C   (C),
    .MUL_LATENCY(2),
    .SIM_DELAY  (1)
  ) dut (
    .mac_array_aclk   (clk),
    .mac_array_aresetn(rstn),
    .mac_array_aclken (aclken),
    .mul_op_a         (op_a),
    .mul_op_b         (op_b),
    .mul_ce           (ce),
    .mul_res          (res),
    .mul_res_vld      (vld),
    .clr_stat         (clr),
    .mul_act_cnt      (cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chkv(input string tag, input logic [K*C*32-1:0] obs,
                      input logic [K*C*32-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_op(input int k, input int j, input logic [15:0] a, input logic [15:0] b);
    op_a[(k*C+j)*16 +: 16] = a;
    op_b[(k*C+j)*16 +: 16] = b;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    rstn   = 1'b0;
    aclken = 1'b1;
    op_a   = '0;
    op_b   = '0;
    ce     = '0;
    clr    = 1'b0;

    // Reset state
    tick();
    chk32("reset_vld", 32'(vld), 32'h0);
    chkv("reset_res", res, '0);
    chk32("reset_cnt", cnt, 32'h0);
    rstn = 1'b1;
    tick();

    // Max positive times min negative, one-cycle capture on lane 0
    set_op(0, 0, 16'h7FFF, 16'h8000);
    ce = 8'h01;
    tick();
    chk32("l2_edge_n_vld", 32'(vld), 32'h0);
    ce = 8'h00;
    tick();
    chk32("l2_vld", 32'(vld), 32'h1);
    chk32("l2_res", res[31:0], 32'hC000_8000);
    tick();
    chk32("l2_vld_one_cycle", 32'(vld), 32'h0);
    chk32("l2_res_hold", res[31:0], 32'hC000_8000);
    chk32("l2_cnt", cnt, 32'd1);

    // All lanes -3 * -5, ten back-to-back captures
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < K; k++) begin
      vcnt[k] = 0;
      for (int j = 0; j < C; j++) set_op(k, j, 16'hFFFD, 16'hFFFB);
    end
    ce = 8'hFF;
    for (int i = 0; i < 12; i++) begin
      if (i == 10) ce = 8'h00;
      tick();
      for (int k = 0; k < K; k++) vcnt[k] += int'(vld[k]);
    end
    for (int k = 0; k < K; k++) chk32("burst_vld_count", 32'(vcnt[k]), 32'd10);
    exp_vec = '0;
    for (int i = 0; i < K*C; i++) exp_vec[i*32 +: 32] = 32'd15;
    chkv("burst_res", res, exp_vec);
    chk32("burst_cnt", cnt, 32'd10);

    // Capture then stall three cycles with aclken low
    set_op(0, 0, 16'd100, 16'hFFFE);
    ce = 8'h01;
    tick();
    ce = 8'h00;
    aclken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk32("stall_vld", 32'(vld), 32'h0);
      chk32("stall_res", res[31:0], 32'd15);
    end
    chk32("stall_cnt", cnt, 32'd11);
    aclken = 1'b1;
    tick();
    chk32("stall_vld_out", 32'(vld), 32'h1);
    chk32("stall_res_out", res[31:0], 32'hFFFF_FF38);

    // Saturation from a preloaded count, then clear wins over increment
    aclken = 1'b0;
    force dut.r_act_cnt = 32'hFFFF_FFFE;
    tick();
    release dut.r_act_cnt;
    aclken = 1'b1;
    ce = 8'h01;
    tick();
    chk32("sat_first", cnt, 32'hFFFF_FFFF);
    tick();
    tick();
    chk32("sat_hold", cnt, 32'hFFFF_FFFF);
    clr = 1'b1;
    tick();
    chk32("clr_priority", cnt, 32'h0);
    clr = 1'b0;
    ce  = 8'h00;
    tick();
    tick();

    // Reset one cycle after capture discards the in-flight product
    do_reset();
    chkv("pre_abort_res", res, '0);
    set_op(1, 2, 16'd7, 16'd9);
    ce = 8'h02;
    tick();
    ce = 8'h00;
    rstn = 1'b0;
    #1;
    chk32("abort_vld_async", 32'(vld), 32'h0);
    chkv("abort_res_async", res, '0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk32("abort_vld", 32'(vld), 32'h0);
      chkv("abort_res", res, '0);
    end
    set_op(1, 2, 16'hFFFF, 16'd2);
    ce = 8'h02;
    tick();
    ce = 8'h00;
    tick();
    chk32("restart_vld", 32'(vld), 32'h02);
    chk32("restart_res", res[(1*C+2)*32 +: 32], 32'hFFFF_FFFE);

    // Lane isolation: distinct operands everywhere, only lane 3 enabled
    do_reset();
    for (int k = 0; k < K; k++)
      for (int j = 0; j < C; j++) set_op(k, j, 16'(k*C+j+1), 16'(-(j+2)));
    ce = 8'h08;
    tick();
    chk32("iso_vld_early", 32'(vld), 32'h0);
    ce = 8'h00;
    tick();
    chk32("iso_vld", 32'(vld), 32'h08);
    exp_vec = '0;
    exp_vec[(3*C+0)*32 +: 32] = -32'sd26;
    exp_vec[(3*C+1)*32 +: 32] = -32'sd42;
    exp_vec[(3*C+2)*32 +: 32] = -32'sd60;
    exp_vec[(3*C+3)*32 +: 32] = -32'sd80;
    chkv("iso_res", res, exp_vec);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
